uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  - UART serial transmitter: frames a parallel byte as start bit, DBIT data bits LSB-first and a stop period.
//  - Drives the tx line.
//  - Bit timing is paced by an external oversampling tick (s_tick, OVERSAMPLE ticks per bit) from the shared baud generator.
//  - Sits between the host-side FIFO/controller and the pad; it is the transmit counterpart of the UART receiver.
// PARAMETERS
//  DBIT        8   number of data bits per frame (5..9)
//  SB_TICK     16  s_ticks in stop period (16=1 stop bit, 24=1.5, 32=2)
//  OVERSAMPLE  16  s_ticks per start/data bit
// PORTS
//  clk           in   1     system clock, all logic on rising edge
//  reset         in   1     synchronous, active-high reset
//  s_tick        in   1     1-clk oversampling enable pulse from baud generator
//  tx_start      in   1     request to send din; sampled only in IDLE
//  din           in   DBIT  byte to transmit; captured when tx_start accepted
//  tx_busy       out  1     high from accept cycle+1 until return to IDLE
//  tx_done_tick  out  1     1-clk pulse when stop period completes
//  tx            out  1     serial line, idle high, registered
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, counters=0.
//    - Reset dominates every other input.
//  - Reset mid-frame: tx=1 on the next edge; frame aborted; no done pulse.
//  - FSM states: IDLE, START, DATA, STOP (encoding from uart_pkg).
//  - IDLE: tx=1. On tx_start=1:
//    - latch din into shift reg b_reg; s_cnt=0; go START.
//    - tx goes 0 on the next edge (1 clk latency from accept to start bit).
//  - START: tx=0.
//    - On each s_tick: s_cnt++.
//    - When s_tick && s_cnt==OVERSAMPLE-1: s_cnt=0, n_cnt=0, go DATA.
//  - DATA: tx=b_reg[0].
//    - On s_tick at s_cnt==OVERSAMPLE-1: s_cnt=0, b_reg>>=1.
//    - If n_cnt==DBIT-1, go STOP; else n_cnt++.
//  - STOP: tx=1.
//    - When s_tick && s_cnt==SB_TICK-1: tx_done_tick=1 for that one clk, go IDLE.
//  - No s_tick: all counters and state hold; no timeout.
//  - tx_start while tx_busy=1: ignored and not queued; din changes during a frame have no effect.
//  - Back-to-back frames: tx_start asserted in the cycle the done pulse occurs is not accepted (state still STOP).
//    - It is accepted on the next clk (IDLE).
//    - So the minimum inter-frame gap is the stop period plus 1 clk.
//  - Widths:
//    - s_cnt is $clog2(max(OVERSAMPLE,SB_TICK)) bits; n_cnt is $clog2(DBIT) bits.
//    - Compares are equality only; counters never wrap past terminal value.
//  - tx is registered (next-state tx_next -> flop), so the line never glitches.
//  - Frame length with s_tick every clk: (1+DBIT)*OVERSAMPLE + SB_TICK clks.
// STRUCTURE
//  - uart_pkg: state enum/localparams (ST_IDLE=2'b00, ST_START=2'b01, ST_DATA=2'b10, ST_STOP=2'b11).
//  - uart_pkg also holds defaults DBIT_DEF=8, OVERSAMPLE_DEF=16, SB_TICK_DEF=16, shared with the receiver.
//  - Single module: state/data registers plus next-state combinational block.
//  - Terminal-count compares inline; no sub-module needed.
// TESTING
//  - Reset: hold reset 3 clks with tx_start=1, din=8'hFF.
//    -> tx=1, tx_busy=0, tx_done_tick=0 throughout; no frame starts.
//  - Single frame: s_tick=1 every clk, din=8'hA5, tx_start 1 clk.
//    -> tx=0 for 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then 1 for 16 clks.
//    -> tx_done_tick pulses exactly once, 160 clks after the accept edge.
//  - Busy ignore: tx_start with din=8'h3C mid-frame of 8'h5A.
//    -> only 8'h5A is observed on tx; one done pulse.
//  - Back-to-back: tx_start held high continuously, din=8'h01 then 8'h80.
//    -> two frames; gap between stop end and next start bit = 1 clk; two done pulses.
//  - Sparse ticks: s_tick every 5th clk, din=8'h0F.
//    -> every bit lasts 80 clks; frame 800 clks; state holds between ticks.
//  - Reset mid-frame: assert reset during data bit 3 of 8'h00.
//    -> tx=1 next clk, tx_busy=0, no done pulse; next tx_start sends a full, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmitter FSM state encoding and the default
// frame parameters, which the transmitter and the receiver both use.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam int DBIT_DEF       = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter. It sends a parallel word as a frame made of
// one start bit (0), DBIT data bits with the LSB first, and a stop period (1).
// An external oversampling tick sets the bit timing.
//
// Ports
//   clk          system clock. All logic runs on the rising edge.
//   reset        synchronous, active-high reset. It overrides every other input.
//   s_tick       1-clk enable pulse from the baud generator. OVERSAMPLE ticks make one bit.
//   tx_start     request to send din. It is sampled only in IDLE.
//   din          data word. It is captured in the cycle tx_start is accepted.
//   tx_busy      high from the cycle after accept until the FSM is back in IDLE.
//   tx_done_tick 1-clk pulse in the last stop-period cycle. The FSM is still in STOP then.
//   tx           serial line, registered, idle high.
//   fsm_state    current FSM state, exposed for debug and checkers.
//
// Handshake: a request is accepted on any rising edge where the FSM is in IDLE
// and tx_start=1. The design has no queue, so a request made outside IDLE is
// dropped. The cycle of the done pulse is still STOP, so a request made in that
// cycle is accepted one clock later.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx,
  output state_t          fsm_state
);

  localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int NW = $clog2(DBIT);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done;

  logic s_last_bit;
  logic s_last_stop;
  logic n_last;

  assign s_last_bit  = (s_cnt_q == SW'(OVERSAMPLE - 1));
  assign s_last_stop = (s_cnt_q == SW'(SB_TICK - 1));
  assign n_last      = (n_cnt_q == NW'(DBIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_cnt_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_last_bit) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_last_bit) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_last) state_d = ST_STOP;
            else        n_cnt_d = n_cnt_q + NW'(1);
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_last_stop) begin
            s_cnt_d = '0;
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is taken from the next state. This way the registered tx
  // changes on the same edge as the state, one clock after accept.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = b_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with the default parameters (8 data bits,
// 16 ticks per bit, 16-tick stop period). It drives inputs on the falling edge
// and samples outputs on the falling edge.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;
  state_t     fsm_state;

  int total = 0;
  int bad   = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // baud tick: one high cycle every tick_div clocks
  always @(posedge clk) begin
    #1;
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Call at a falling edge. The request is placed in a cycle where s_tick is
  // high, so the start bit is exactly 16 ticks long for any tick_div.
  task automatic send(input logic [7:0] b, input bit hold);
    int w;
    w = 0;
    while (!s_tick && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("tick_align", 32'(w < 20), 32'd1);
    din      = b;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_start = 1'b0;
  endtask

  // Checks the whole frame, one cycle at a time, starting from the cycle after
  // the accept edge. Cycle k: start bit for k < bc, data bit (k-bc)/bc for
  // k < 9*bc, then stop. The done pulse comes in the last cycle (k = total-1).
  task automatic check_frame(input string tag, input logic [7:0] b, input int div);
    int bc, len, bad_cyc, dn, done_at;
    logic exp_tx;
    state_t st_at;
    bc = 16 * div;
    len = 9 * bc + 16 * div;
    bad_cyc = 0; dn = 0; done_at = -1; st_at = ST_IDLE;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k < bc)          exp_tx = 1'b0;
      else if (k < 9 * bc) exp_tx = b[(k - bc) / bc];
      else                 exp_tx = 1'b1;
      if (tx !== exp_tx) bad_cyc++;
      if ((k % bc) == bc / 2 && k < 9 * bc)
        check($sformatf("%s_bit%0d", tag, k / bc), 32'(tx), 32'(exp_tx));
      if (k == bc / 2) check({tag, "_busy"}, 32'(tx_busy), 32'd1);
      if (tx_done_tick) begin
        dn++;
        done_at = k;
        st_at = fsm_state;
      end
    end
    check({tag, "_trace_bad_cycles"}, 32'(bad_cyc), 32'd0);
    check({tag, "_done_count"}, 32'(dn), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(len - 1));
    check({tag, "_done_state"}, 32'(st_at), 32'(ST_STOP));
  endtask

  initial begin : main
    int dcount;
    // reset held with a pending request
    reset = 1'b1; tx_start = 1'b1; din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_tx%0d", i), 32'(tx), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(tx_busy), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(tx_done_tick), 32'd0);
      check($sformatf("rst_state%0d", i), 32'(fsm_state), 32'(ST_IDLE));
    end
    tx_start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(tx_busy), 32'd0);

    // single frame, tick every clock
    send(8'hA5, 1'b0);
    check_frame("a5", 8'hA5, 1);
    @(negedge clk);
    check("a5_after_state", 32'(fsm_state), 32'(ST_IDLE));

    // a request during the frame is ignored and not queued
    send(8'h5A, 1'b0);
    fork
      check_frame("5a", 8'h5A, 1);
      begin
        repeat (50) @(negedge clk);
        din = 8'h3C; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("ignore_busy", 32'(tx_busy), 32'd0);
    check("ignore_tx", 32'(tx), 32'd1);

    // back-to-back with tx_start held high
    send(8'h01, 1'b1);
    fork
      check_frame("b2b1", 8'h01, 1);
      begin
        repeat (10) @(negedge clk);
        din = 8'h80;
      end
    join
    @(negedge clk);
    check("gap_state", 32'(fsm_state), 32'(ST_IDLE));
    check("gap_tx", 32'(tx), 32'd1);
    check("gap_busy", 32'(tx_busy), 32'd0);
    check_frame("b2b2", 8'h80, 1);
    tx_start = 1'b0;
    repeat (3) @(negedge clk);

    // sparse ticks: one every 5th clock
    tick_div = 5;
    repeat (6) @(negedge clk);
    send(8'h0F, 1'b0);
    check_frame("sparse", 8'h0F, 5);
    tick_div = 1;
    repeat (6) @(negedge clk);

    // reset during data bit 3 (cycles 64..79 after accept)
    send(8'h00, 1'b0);
    repeat (71) @(negedge clk);
    check("pre_rst_state", 32'(fsm_state), 32'(ST_DATA));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_done_tick) dcount++;
    end
    check("mid_rst_no_done", 32'(dcount), 32'd0);
    check("mid_rst_idle_tx", 32'(tx), 32'd1);
    send(8'h00, 1'b0);
    check_frame("post_rst", 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
